// File: rtl/bru_resolve_pkg.sv
// Shared opcode/funct3 constants, bus widths and decode helpers for the branch resolution unit.
package bru_resolve_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {ST_IDLE, ST_RECOVER} state_t;

  typedef struct packed {
    logic              valid;
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
    logic              prd_taken;
    logic [XLEN-1:0]   prd_addr;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
  } ex_t;

  function automatic logic [XLEN-1:0] imm_i(input logic [INST_W-1:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [XLEN-1:0] imm_b(input logic [INST_W-1:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_j(input logic [INST_W-1:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/bru_resolve_if.sv
// ID-stage operand bundle into the resolver and the flush/redirect response back out.
interface bru_resolve_if;
  import bru_resolve_pkg::*;

  logic              id_valid_i;
  logic [INST_W-1:0] id_inst_i;
  logic [XLEN-1:0]   id_instaddr_i;
  logic              id_prd_taken_i;
  logic [XLEN-1:0]   id_prd_addr_i;
  logic [XLEN-1:0]   id_rs1_data_i;
  logic [XLEN-1:0]   id_rs2_data_i;
  logic              stall_i;
  logic              flush_o;
  logic              redirect_en_o;
  logic [XLEN-1:0]   redirect_addr_o;

  modport master (
    output id_valid_i, id_inst_i, id_instaddr_i, id_prd_taken_i, id_prd_addr_i,
           id_rs1_data_i, id_rs2_data_i, stall_i,
    input  flush_o, redirect_en_o, redirect_addr_o
  );

  modport slave (
    input  id_valid_i, id_inst_i, id_instaddr_i, id_prd_taken_i, id_prd_addr_i,
           id_rs1_data_i, id_rs2_data_i, stall_i,
    output flush_o, redirect_en_o, redirect_addr_o
  );

endinterface

// File: rtl/bru_cmp.sv
// Combinational conditional-branch evaluator; undefined funct3 encodings evaluate as not taken.
module bru_cmp
  import bru_resolve_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_taken = (i_rs1 == i_rs2);
      F3_BNE:  o_taken = (i_rs1 != i_rs2);
      F3_BLT:  o_taken = ($signed(i_rs1) <  $signed(i_rs2));
      F3_BGE:  o_taken = ($signed(i_rs1) >= $signed(i_rs2));
      F3_BLTU: o_taken = (i_rs1 <  i_rs2);
      F3_BGEU: o_taken = (i_rs1 >= i_rs2);
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/bru_resolve.sv
// EX-stage branch resolver: mispredict raises a registered one-cycle flush/redirect (RECOVER), which outranks stall.
// Optional perf counters under BRU_PERF_CNT_EN; otherwise the counter ports are tied to zero.
module bru_resolve
  import bru_resolve_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  bru_resolve_if.slave     bus,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  state_t          r_state;
  ex_t             r_ex;
  logic            r_flush;
  logic            r_redir_en;
  logic [XLEN-1:0] r_redir_addr;

  ex_t             w_id;
  logic [6:0]      w_opc;
  logic            w_is_br;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_cmp_taken;
  logic            w_act_taken;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_redir_addr;
  logic            w_resolve;
  logic            w_mispred;

  assign w_id = '{valid:     bus.id_valid_i,
                  inst:      bus.id_inst_i,
                  pc:        bus.id_instaddr_i,
                  prd_taken: bus.id_prd_taken_i,
                  prd_addr:  bus.id_prd_addr_i,
                  rs1:       bus.id_rs1_data_i,
                  rs2:       bus.id_rs2_data_i};

  assign w_opc     = r_ex.inst[6:0];
  assign w_is_br   = (w_opc == OPC_BRANCH);
  assign w_is_jal  = (w_opc == OPC_JAL);
  assign w_is_jalr = (w_opc == OPC_JALR);

  bru_cmp u_cmp (
    .i_funct3 (r_ex.inst[14:12]),
    .i_rs1    (r_ex.rs1),
    .i_rs2    (r_ex.rs2),
    .o_taken  (w_cmp_taken)
  );

  assign w_act_taken  = w_is_br ? w_cmp_taken : (w_is_jal | w_is_jalr);
  assign w_target     = w_is_jalr ? ((r_ex.rs1 + imm_i(r_ex.inst)) & ~32'h1) :
                        w_is_jal  ? (r_ex.pc + imm_j(r_ex.inst)) :
                                    (r_ex.pc + imm_b(r_ex.inst));
  assign w_redir_addr = w_act_taken ? w_target : (r_ex.pc + 32'd4);

  // The EX slot during RECOVER holds wrong-path work, so it must never resolve.
  assign w_resolve = r_ex.valid && !bus.stall_i && (r_state == ST_IDLE);
  assign w_mispred = w_resolve &&
                     ((w_act_taken != r_ex.prd_taken) ||
                      (w_act_taken && r_ex.prd_taken && (w_target != r_ex.prd_addr)));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_ex         <= '0;
      r_flush      <= 1'b0;
      r_redir_en   <= 1'b0;
      r_redir_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mispred) r_state <= ST_RECOVER;
          if (!bus.stall_i) r_ex <= w_id;
        end
        ST_RECOVER: begin
          r_state    <= ST_IDLE;
          r_ex.valid <= 1'b0;
        end
      endcase
      r_flush      <= w_mispred;
      r_redir_en   <= w_mispred;
      r_redir_addr <= w_mispred ? w_redir_addr : '0;
    end
  end

  assign bus.flush_o         = r_flush;
  assign bus.redirect_en_o   = r_redir_en;
  assign bus.redirect_addr_o = r_redir_addr;

`ifdef BRU_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_is_ctl;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mp_cnt;

  assign w_is_ctl = w_is_br | w_is_jal | w_is_jalr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else begin
      if (w_resolve && w_is_ctl && (r_br_cnt != '1)) r_br_cnt <= r_br_cnt + CNT_ONE;
      if (w_mispred && (r_mp_cnt != '1))             r_mp_cnt <= r_mp_cnt + CNT_ONE;
    end
  end

  assign branch_cnt_o  = r_br_cnt;
  assign mispred_cnt_o = r_mp_cnt;
`else
  assign branch_cnt_o  = '0;
  assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bru_resolve.sv
// Scoreboard bench for bru_resolve: ISA-level reference model predicts redirects and counter values.
module tb_bru_resolve;

  localparam int CNT_W = 32;
`ifdef BRU_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  bru_resolve_if bus();

  bru_resolve #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .bus           (bus),
    .branch_cnt_o  (branch_cnt),
    .mispred_cnt_o (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] pa;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } mex_t;

  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_q[$];

  mex_t        m_ex;
  bit          m_rec;
  logic [31:0] m_br, m_mp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3, input logic [11:0] imm);
    return {imm, 5'd1, f3, 5'd1, opc};
  endfunction

  // Jump/branch destination straight from the ISA immediate formats.
  function automatic logic [31:0] ref_target(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs1);
    logic [31:0] ii, ib, ij;
    ii = {{20{inst[31]}}, inst[31:20]};
    ib = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    ij = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    case (inst[6:0])
      7'b1101111: return pc + ij;
      7'b1100111: return (rs1 + ii) & 32'hFFFF_FFFE;
      default:    return pc + ib;
    endcase
  endfunction

  function automatic void ref_resolve(input mex_t e, output bit ctl, output bit mis, output logic [31:0] addr);
    bit          taken;
    logic [31:0] tgt;
    ctl   = 1'b1;
    taken = 1'b0;
    case (e.inst[6:0])
      7'b1100011: begin
        case (e.inst[14:12])
          3'd0:    taken = (e.rs1 == e.rs2);
          3'd1:    taken = (e.rs1 != e.rs2);
          3'd4:    taken = ($signed(e.rs1) <  $signed(e.rs2));
          3'd5:    taken = ($signed(e.rs1) >= $signed(e.rs2));
          3'd6:    taken = (e.rs1 <  e.rs2);
          3'd7:    taken = (e.rs1 >= e.rs2);
          default: taken = 1'b0;
        endcase
      end
      7'b1101111, 7'b1100111: taken = 1'b1;
      default: ctl = 1'b0;
    endcase
    tgt  = ref_target(e.inst, e.pc, e.rs1);
    mis  = (taken != e.pt) || (taken && e.pt && (tgt != e.pa));
    addr = taken ? tgt : e.pc + 32'd4;
  endfunction

  // Drive one cycle of inputs, advance the model across the coming edge, then commit its expectations.
  task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc, input logic pt,
                       input logic [31:0] pa, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic st, input logic rn);
    mex_t        id, nx_ex;
    bit          nx_rec, ctl, mis, push;
    logic [31:0] addr, nx_br, nx_mp;
    rstn               = rn;
    bus.id_valid_i     = v;
    bus.id_inst_i      = inst;
    bus.id_instaddr_i  = pc;
    bus.id_prd_taken_i = pt;
    bus.id_prd_addr_i  = pa;
    bus.id_rs1_data_i  = rs1;
    bus.id_rs2_data_i  = rs2;
    bus.stall_i        = st;
    id    = '{v:v, inst:inst, pc:pc, pt:pt, pa:pa, rs1:rs1, rs2:rs2};
    push  = 1'b0;
    addr  = '0;
    nx_br = m_br;
    nx_mp = m_mp;
    if (!rn) begin
      nx_ex  = '0;
      nx_rec = 1'b0;
      nx_br  = '0;
      nx_mp  = '0;
    end else begin
      nx_rec = 1'b0;
      if (m_ex.v && !st && !m_rec) begin
        ref_resolve(m_ex, ctl, mis, addr);
        if (PERF && ctl && m_br != 32'hFFFF_FFFF) nx_br = m_br + 1;
        if (PERF && mis && m_mp != 32'hFFFF_FFFF) nx_mp = m_mp + 1;
        push   = mis;
        nx_rec = mis;
      end
      if (m_rec)   begin nx_ex = m_ex; nx_ex.v = 1'b0; end
      else if (st) nx_ex = m_ex;
      else         nx_ex = id;
    end
    @(posedge clk);
    m_ex   = nx_ex;
    m_rec  = nx_rec;
    m_br   = nx_br;
    m_mp   = nx_mp;
    if (push) exp_q.push_back(addr);
    mon_en = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h13, '0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("flush_vs_redirect_en", {63'd0, bus.flush_o}, {63'd0, bus.redirect_en_o});
      if (bus.redirect_en_o === 1'b1) begin
        chk("redirect_expected", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) chk("redirect_addr", {32'd0, bus.redirect_addr_o}, {32'd0, exp_q.pop_front()});
      end else begin
        chk("idle_redirect_addr", {32'd0, bus.redirect_addr_o}, 64'd0);
      end
      chk("branch_cnt", {32'd0, branch_cnt}, {32'd0, m_br});
      chk("mispred_cnt", {32'd0, mispred_cnt}, {32'd0, m_mp});
    end
  end

  initial begin
    logic [31:0] inst, pc, rs1, rs2, pa;
    logic [6:0]  opc;
    int          sel;
    m_ex  = '0;
    m_rec = 1'b0;
    m_br  = '0;
    m_mp  = '0;
    cycle(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    idle(2);

    // BEQ taken to 0x0F0, correctly predicted
    cycle(1'b1, enc_b(3'd0, -13'sd16), 32'h100, 1'b1, 32'hF0, 32'd5, 32'd5, 1'b0, 1'b1);
    idle(3);
    // BNE not taken but predicted taken -> redirect 0x204
    cycle(1'b1, enc_b(3'd1, 13'd16), 32'h200, 1'b1, 32'h210, 32'd3, 32'd3, 1'b0, 1'b1);
    idle(4);
    // JALR to (0x1001+4)&~1 = 0x1004, correctly predicted
    cycle(1'b1, enc_i(7'b1100111, 3'd0, 12'd4), 32'h300, 1'b1, 32'h1004, 32'h1001, 32'd0, 1'b0, 1'b1);
    idle(3);
    // BLTU held by a 3-cycle stall, wrong-path ADD sits in ID meanwhile
    cycle(1'b1, enc_b(3'd6, 13'd8), 32'h500, 1'b1, 32'h508, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h0020_81B3, 32'h600, 1'b1, 32'h0, 32'd0, 32'd0, 1'b1, 1'b1);
    idle(4);
    // Mispredict, then reset lands in the RECOVER cycle
    cycle(1'b1, 32'h0020_81B3, 32'h700, 1'b1, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1);
    idle(1);
    cycle(1'b0, 32'h13, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    idle(3);
    // ADD predicted taken, followed back-to-back by wrong-path instructions
    cycle(1'b1, 32'h0020_81B3, 32'h400, 1'b1, 32'h0, 32'd1, 32'd2, 1'b0, 1'b1);
    cycle(1'b1, enc_b(3'd1, 13'd32), 32'h404, 1'b1, 32'h424, 32'd9, 32'd9, 1'b0, 1'b1);
    cycle(1'b1, 32'h0020_81B3, 32'h408, 1'b1, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1);
    idle(4);

    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0, 1, 2: opc = 7'b1100011;
        3:       opc = 7'b1101111;
        4:       opc = 7'b1100111;
        5:       opc = 7'b0110011;
        default: opc = 7'b0010011;
      endcase
      inst      = $urandom;
      inst[6:0] = opc;
      pc        = $urandom & 32'hFFFF_FFFC;
      rs1       = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : $urandom;
      rs2       = ($urandom_range(0, 2) == 0) ? rs1 : (($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : $urandom);
      pa        = ($urandom_range(0, 1) == 0) ? ref_target(inst, pc, rs1) : $urandom;
      cycle($urandom_range(0, 4) != 0, inst, pc, 1'($urandom_range(0, 1)), pa, rs1, rs2,
            $urandom_range(0, 3) == 0, $urandom_range(0, 99) != 0);
    end
    idle(6);
    chk("missed_redirects", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
